axis2row: RTL

- AXI4-Stream slave that receives a stream of DWIDTH-bit pixel colors and packs them into one WIDTH-bit row of cell states for the conware computation core.
- Pixel k of a packet maps to bit k of the row: 1 if the pixel equals alive_color, 0 otherwise.
- Presents the completed row on a valid/ready interface.
- Sits at the input side of the core, as the inverse of the row-to-stream output path.

---
 rtl/conware_pkg.sv | 17 +
 rtl/axis2row.sv | 97 +++++++++
 2 files changed

// File: rtl/conware_pkg.sv
// Shared definitions for the conware stream/row converters: FSM encoding,
// default geometry and frame_err bit positions.
package conware_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_WIDTH  = 4;

  localparam int FERR_EARLY_LAST   = 0;
  localparam int FERR_MISSING_LAST = 1;

endpackage

// File: rtl/axis2row.sv
// AXI4-Stream pixel slave that packs one packet of WIDTH pixels into a row of cell bits.
// Optional sticky framing-error flags when AXIS2ROW_FRAME_CHECK_EN is defined.
//
// state | meaning
// INIT  | reset state, moves to FILL on the next cycle
// FILL  | accepting beats, TREADY high
// HOLD  | row presented on out_data with out_valid high
module axis2row
  import conware_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int WIDTH  = DEF_WIDTH,
  localparam int CWIDTH = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
`ifdef AXIS2ROW_FRAME_CHECK_EN
  output logic [1:0]        frame_err,
`endif
  input  logic              out_ready
);

  state_t            state;
  logic [CWIDTH-1:0] counter;
  logic              beat_ok;
  logic              last_slot;
  logic              pixel_alive;

  assign beat_ok     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_slot   = (counter == CWIDTH'(WIDTH - 1));
  assign pixel_alive = (S_AXIS_TDATA == alive_color);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= INIT;
      counter       <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      S_AXIS_TREADY <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state         <= FILL;
          S_AXIS_TREADY <= 1'b1;
        end
        FILL: begin
          if (beat_ok) begin
            out_data[counter] <= pixel_alive;
            // Row closes on TLAST or a full row; no resync to TLAST afterwards.
            if (last_slot || S_AXIS_TLAST) begin
              state         <= HOLD;
              counter       <= '0;
              out_valid     <= 1'b1;
              S_AXIS_TREADY <= 1'b0;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state         <= FILL;
            out_data      <= '0;
            out_valid     <= 1'b0;
            S_AXIS_TREADY <= 1'b1;
          end
        end
        default: begin
          state         <= INIT;
          counter       <= '0;
          out_data      <= '0;
          out_valid     <= 1'b0;
          S_AXIS_TREADY <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS2ROW_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_err <= 2'b00;
    end else if (state == FILL && beat_ok) begin
      if (S_AXIS_TLAST && !last_slot) frame_err[FERR_EARLY_LAST] <= 1'b1;
      if (!S_AXIS_TLAST && last_slot) frame_err[FERR_MISSING_LAST] <= 1'b1;
    end
  end
`endif

endmodule
